pulse_param_ctrl: RTL

Configuration controller for the pulse generator datapath. It parses command frames arriving as bytes from the UART receiver into shadow registers. On an explicit apply command it transfers the whole shadow set to the active `per`/`p1wid`/`del`/`p2wid`/`p_bl`/`p_bl_off`/`pump`/`cpmg`/`block` outputs. The transfer happens only at a pulse-period boundary, so a running sequence never sees a mixed parameter set. It also returns a one-byte acknowledge or error code to the UART transmitter.

---
 rtl/pulse_param_ctrl_if.sv | 12 +
 rtl/pulse_param_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pulse_param_ctrl_if.sv
// UART byte channel between the receiver/transmitter and the parameter
// controller. master = UART side, slave = controller side.
interface pulse_param_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/pulse_param_ctrl.sv
// Pulse generator configuration controller: parses UART command frames into
// shadow registers and moves the whole shadow set to the active outputs at a
// period boundary once an apply command has armed the transfer.
module pulse_param_ctrl #(
  parameter int          TIMEOUT     = 2000000,
  parameter logic [31:0] DEF_PER     = 32'd201000,
  parameter logic [31:0] DEF_P1WID   = 32'd30,
  parameter logic [31:0] DEF_DEL     = 32'd200,
  parameter logic [31:0] DEF_P2WID   = 32'd30,
  parameter logic [7:0]  DEF_PBL     = 8'd50,
  parameter logic [15:0] DEF_PBLOFF  = 16'd100,
  parameter logic [2:0]  DEF_FLAGS   = 3'b111
) (
  input  logic                 clk_pll,
  input  logic                 reset,
  pulse_param_ctrl_if.slave    uart,
  input  logic                 cycle_start,
  output logic [31:0]          per,
  output logic [31:0]          p1wid,
  output logic [31:0]          del,
  output logic [31:0]          p2wid,
  output logic [7:0]           p_bl,
  output logic [15:0]          p_bl_off,
  output logic                 pump,
  output logic                 cpmg,
  output logic                 block,
  output logic                 pending,
  output logic                 updated,
  output logic                 err
);

  // Idle counter only needs to reach TIMEOUT-1; the edge that would make it
  // TIMEOUT is the one that abandons the frame.
  localparam int          TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]  CMD_APPLY = 8'h0F;
  localparam logic [7:0]  RSP_ERR   = 8'hEE;

  typedef enum logic {IDLE, PAY} state_t;

  state_t        state;
  logic [7:0]    cmd;
  logic [1:0]    cnt;
  logic [31:0]   asm_q;
  logic [TW-1:0] tcnt;

  logic [31:0] s_per, s_p1wid, s_del, s_p2wid;
  logic [7:0]  s_pbl;
  logic [15:0] s_pbloff;
  logic [2:0]  s_flags;   // {block, cpmg, pump}
  logic [2:0]  a_flags;

  logic [31:0] asm_next;
  logic        xfer;
  logic        is_cfg;

  assign asm_next = {asm_q[23:0], uart.rx_data};
  // pending is the registered value, so an apply byte arriving together with
  // cycle_start cannot transfer on that same strobe.
  assign xfer     = pending && cycle_start;
  assign is_cfg   = (uart.rx_data != 8'h00) && (uart.rx_data <= 8'h07);

  assign pump  = a_flags[0];
  assign cpmg  = a_flags[1];
  assign block = a_flags[2];

  // Frame parser, shadow registers, timeout, apply arming and response byte.
  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cmd           <= 8'h00;
      cnt           <= 2'd0;
      asm_q         <= 32'h0;
      tcnt          <= '0;
      pending       <= 1'b0;
      err           <= 1'b0;
      uart.tx_data  <= 8'h00;
      uart.tx_valid <= 1'b0;
      s_per         <= DEF_PER;
      s_p1wid       <= DEF_P1WID;
      s_del         <= DEF_DEL;
      s_p2wid       <= DEF_P2WID;
      s_pbl         <= DEF_PBL;
      s_pbloff      <= DEF_PBLOFF;
      s_flags       <= DEF_FLAGS;
    end else begin
      err <= 1'b0;
      if (uart.tx_ready) uart.tx_valid <= 1'b0;
      if (xfer) pending <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (uart.rx_valid) begin
            if (is_cfg) begin
              cmd   <= uart.rx_data;
              cnt   <= 2'd0;
              state <= PAY;
            end else if (uart.rx_data == CMD_APPLY) begin
              pending       <= 1'b1;
              uart.tx_data  <= CMD_APPLY;
              uart.tx_valid <= 1'b1;
            end else begin
              err           <= 1'b1;
              uart.tx_data  <= RSP_ERR;
              uart.tx_valid <= 1'b1;
            end
          end
        end
        PAY: begin
          if (uart.rx_valid) begin
            asm_q <= asm_next;
            cnt   <= cnt + 2'd1;
            tcnt  <= '0;
            if (cnt == 2'd3) begin
              case (cmd)
                8'h01:   s_per    <= asm_next;
                8'h02:   s_p1wid  <= asm_next;
                8'h03:   s_del    <= asm_next;
                8'h04:   s_p2wid  <= asm_next;
                8'h05:   s_pbl    <= asm_next[7:0];
                8'h06:   s_pbloff <= asm_next[15:0];
                8'h07:   s_flags  <= asm_next[2:0];
                default: ;
              endcase
              uart.tx_data  <= cmd;
              uart.tx_valid <= 1'b1;
              state         <= IDLE;
            end
          end else if (tcnt == TLAST) begin
            tcnt          <= '0;
            err           <= 1'b1;
            uart.tx_data  <= RSP_ERR;
            uart.tx_valid <= 1'b1;
            state         <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Active set: copied from the shadows only on an armed cycle_start.
  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      per      <= DEF_PER;
      p1wid    <= DEF_P1WID;
      del      <= DEF_DEL;
      p2wid    <= DEF_P2WID;
      p_bl     <= DEF_PBL;
      p_bl_off <= DEF_PBLOFF;
      a_flags  <= DEF_FLAGS;
      updated  <= 1'b0;
    end else begin
      updated <= xfer;
      if (xfer) begin
        per      <= s_per;
        p1wid    <= s_p1wid;
        del      <= s_del;
        p2wid    <= s_p2wid;
        p_bl     <= s_pbl;
        p_bl_off <= s_pbloff;
        a_flags  <= s_flags;
      end
    end
  end

endmodule
